// File: rtl/instruction_fetch_decoder.sv
// Byte-serial instruction fetcher: reads opcode/operand bytes, decodes length, presents one instruction.
// Latency: an N-byte instruction is presented N cycles after its first request with zero-wait memory.
// Backpressure: holds the presented instruction while ope_ready=0; memory stalls by withholding mem_ack.
module instruction_fetch_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        redirect,
  input  logic [31:0] start_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [31:0] ope,
  output logic [3:0]  num_of_ope,
  output logic [31:0] ope_addr,
  output logic        ope_valid,
  input  logic        ope_ready,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;     // address of the opcode byte of the current instruction
  logic [2:0]  cnt_q, cnt_d;   // index of the next byte to fetch (0..4)
  logic [31:0] ope_q, ope_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  len_now;        // length as known once the byte being accepted is included

  // Primary length decode from the opcode; 0 marks an unknown opcode.
  // The 83 7d form is refined to 4 bytes once byte 1 arrives.
  function automatic logic [3:0] decode_len(input logic [7:0] op);
    case (op)
      8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9: decode_len = 4'd1;
      8'h89, 8'h6a, 8'h75, 8'heb:        decode_len = 4'd2;
      8'h8b, 8'h83:                      decode_len = 4'd3;
      8'hb8, 8'he8:                      decode_len = 4'd5;
      default:                           decode_len = 4'd0;
    endcase
  endfunction

  // Next-state logic: redirect beats start beats the byte/consumer handshakes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ope_d   = ope_q;
    len_d   = len_q;
    len_now = len_q;

    if (cnt_q == 3'd0) begin
      len_now = decode_len(mem_data);
    end else if (cnt_q == 3'd1 && ope_q[31:24] == 8'h83 && mem_data == 8'h7d) begin
      len_now = 4'd4;
    end

    if (redirect) begin
      // Any in-flight byte (even one acked this edge) is dropped.
      state_d = S_FETCH;
      pc_d    = start_addr;
      cnt_d   = 3'd0;
      ope_d   = 32'h0;
      len_d   = 4'd0;
    end else if (start && (state_q == S_IDLE || state_q == S_HALT)) begin
      state_d = S_FETCH;
      pc_d    = start_addr;
      cnt_d   = 3'd0;
      ope_d   = 32'h0;
      len_d   = 4'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            if (len_now == 4'd0) begin
              // Unknown opcode: stop requesting and flag it.
              state_d = S_HALT;
              cnt_d   = 3'd0;
              len_d   = 4'd0;
            end else begin
              case (cnt_q)
                3'd0:    ope_d[31:24] = mem_data;
                3'd1:    ope_d[23:16] = mem_data;
                3'd2:    ope_d[15:8]  = mem_data;
                3'd3:    ope_d[7:0]   = mem_data;
                default: ope_d        = ope_q;  // fifth byte only advances the count
              endcase
              len_d = len_now;
              if ({1'b0, cnt_q} + 4'd1 == len_now) begin
                state_d = S_PRESENT;
                cnt_d   = 3'd0;
              end else begin
                cnt_d = cnt_q + 3'd1;
              end
            end
          end
        end
        S_PRESENT: begin
          if (ope_ready) begin
            state_d = S_FETCH;
            pc_d    = pc_q + {28'h0, len_q};
            cnt_d   = 3'd0;
            ope_d   = 32'h0;
            len_d   = 4'd0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= 32'h0;
      cnt_q   <= 3'd0;
      ope_q   <= 32'h0;
      len_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ope_q   <= ope_d;
      len_q   <= len_d;
    end
  end

  // Outputs decode directly from registered state so they are glitch-free and stable per cycle.
  always_comb begin
    mem_req    = (state_q == S_FETCH);
    mem_addr   = (state_q == S_FETCH) ? (pc_q + {29'h0, cnt_q}) : 32'h0;
    ope        = ope_q;
    num_of_ope = len_q;
    ope_addr   = pc_q;
    ope_valid  = (state_q == S_PRESENT);
    illegal    = (state_q == S_HALT);
  end

endmodule

// File: doc/instruction_fetch_decoder.md
INSTRUCTION_FETCH_DECODER -- requirements
Module: instruction_fetch_decoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock and reset are the only timing inputs.
REQ-002 SHALL provide `clock  in  1`: all state updates on its rising edge.
REQ-003 SHALL provide `reset  in  1`: synchronous, active-high.
REQ-004 SHALL provide `start  in  1`: one-cycle pulse; loads start_addr and begins fetching.
REQ-005 SHALL provide `redirect  in  1`: one-cycle pulse; loads start_addr and aborts the current fetch (branch, call, ret).
REQ-006 SHALL provide `start_addr  in  32`: byte address loaded on start or redirect.
REQ-007 SHALL provide `mem_req  out  1`: byte read request.
REQ-008 SHALL provide `mem_addr  out  32`: byte address, stable while mem_req=1.
REQ-009 SHALL provide `mem_ack  in  1`: read complete; mem_data valid this cycle.
REQ-010 SHALL provide `mem_data  in  8`: returned byte.
REQ-011 SHALL provide `ope  out  32`: instruction window; opcode in [31:24], next bytes in [23:16], [15:8], [7:0].
REQ-012 SHALL provide `num_of_ope  out  4`: instruction length in bytes.
REQ-013 SHALL provide `ope_addr  out  32`: address of the opcode byte of the presented instruction.
REQ-014 SHALL provide `ope_valid  out  1`: ope, num_of_ope and ope_addr are valid.
REQ-015 SHALL provide `ope_ready  in  1`: consumer accepts the presented instruction.
REQ-016 SHALL provide `illegal  out  1`: unknown opcode; fetching is halted.

Function
REQ-017 SHALL implement these states: IDLE, FETCH, PRESENT, HALT.
REQ-018 In IDLE, start=1 SHALL load pc<=start_addr and move to FETCH with byte count 0 and ope cleared to 0.
REQ-019 In FETCH, the block SHALL drive mem_req=1 and mem_addr=pc+byte_count.
REQ-020 A byte SHALL be accepted on an edge where mem_req&mem_ack=1.
REQ-021 An accepted byte at index 0..3 SHALL be written to ope[31-8i:24-8i]; index 4 is fetched and discarded.
REQ-022 Length SHALL be decoded from byte 0 as follows:
- 55, 53, 5d, c3, c9 -> 1
- 89, 6a, 75, eb -> 2
- 8b -> 3
- 83 -> 3, except when byte 1 = 7d, which gives 4
- b8, e8 -> 5
REQ-023 An opcode not in REQ-022 SHALL cause: no further request, state HALT, illegal=1 on the next cycle, ope_valid=0.
REQ-024 On the edge accepting the last byte (index = length-1), state SHALL go to PRESENT, with ope_valid=1 and mem_req=0 from the next cycle.
REQ-025 ope bytes beyond the length SHALL read 0.
REQ-026 In PRESENT, all outputs SHALL hold while ope_ready=0.
REQ-027 On an edge with ope_valid&ope_ready=1, the block SHALL apply pc<=pc+num_of_ope (32-bit modulo, wrapping at FFFFFFFF) and ope<=0, and enter FETCH; mem_req=1 on the next cycle.
REQ-028 redirect SHALL take effect from any state, including mid-byte and while PRESENT: pc<=start_addr, enter FETCH, ope_valid=0 and illegal=0 next cycle.
REQ-029 An ack arriving on the same edge as redirect SHALL be discarded.
REQ-030 Priority on any edge SHALL be reset > redirect > start > handshake.
REQ-031 start SHALL be ignored outside IDLE and HALT.
REQ-032 mem_ack SHALL be ignored when mem_req=0.
REQ-033 An abandoned request (on redirect or reset) is not completed; memory SHALL tolerate it.
REQ-034 Throughput with zero-wait memory (ack every requested cycle) SHALL be: an N-byte instruction is valid N cycles after its first mem_req cycle.

Reset
REQ-035 reset=1 at an edge SHALL force:
- state IDLE, pc=0, byte count 0
- ope=0, num_of_ope=0, ope_addr=0
- ope_valid=0, illegal=0, mem_req=0, mem_addr=0
REQ-036 Reset during FETCH or PRESENT SHALL discard all partial state.
REQ-037 The block SHALL stay in IDLE until start.

Verification
REQ-038 Bench SHALL cover this case: memory at 0 = 55 89 e5 83 ec 10, zero-wait, ope_ready=1. Required: 55000000/len1/addr0, then 89e50000/len2/addr1, then 83ec1000/len3/addr3.
REQ-039 Bench SHALL cover this case: bytes 83 7d f8 00 at 0x40, then e8 ee ff ff ff. Required: ope=837df800 len4, then ope=e8eeffff len5 addr 0x44; the next fetch address is 0x49.
REQ-040 Bench SHALL cover this case: ope_ready=0 for 5 cycles while presenting 6a 05. Required: ope=6a050000 held stable, mem_req=0, and fetch of pc+2 starts only after the ready edge.
REQ-041 Bench SHALL cover this case: redirect with start_addr=0x100 after byte 1 of b8 is accepted, with ack coincident. Required: ack byte dropped, mem_addr=0x100 next cycle, no ope_valid for the aborted instruction.
REQ-042 Bench SHALL cover this case: opcode 0x0f at 0x20. Required: illegal=1, mem_req=0 held; a following start at 0 clears illegal and resumes.
REQ-043 Bench SHALL cover this case: reset asserted mid-FETCH with random ack delays 0-3 cycles. Required: all outputs 0 next cycle, and no request until start.
